mult_err_monitor: RTL and testbench
===================================

Name: mult_err_monitor

Overview:
- Sequential error-metric collector placed directly downstream of an 8x8 approximate multiplier (e.g. an OR-compressed 4x4-partitioned design).
- Accepts operand pairs A,B with the multiplier's 16-bit approximate result R, computes the exact product internally, and accumulates error statistics over a run of N samples.
- Provides characterisation results in silicon/FPGA without a software golden model: total absolute error, signed bias, maximum error and erroneous-sample count.

Parameters:
- CNT_W, 16, width of the sample counter and of num_samples; a run holds at most 2^CNT_W-1 samples.
- SUM_W, 16+CNT_W, width of the absolute-error accumulator; it must not overflow for any legal run.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that arms a run; honoured only in IDLE or DONE
- num_samples  in  CNT_W  number of samples in the run; captured when start is accepted
- in_valid  in  1  sample present on a, b, r_approx
- in_ready  out  1  block accepts a sample this cycle
- a  in  8  multiplicand
- b  in  8  multiplier
- r_approx  in  16  approximate product under test
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE, held until the next accepted start
- sum_abs_err  out  SUM_W  sum of |a*b - r_approx|
- sum_sgn_err  out  SUM_W+1  two's-complement sum of (r_approx - a*b)
- max_abs_err  out  16  largest |a*b - r_approx| seen in the run
- err_count  out  CNT_W  samples with r_approx != a*b
- sample_count  out  CNT_W  samples accumulated

Behaviour:
- Reset, asynchronous, active-low:
  - state=IDLE.
  - in_ready, busy and done = 0.
  - All result outputs = 0.
  - Pipeline valid bits cleared.
- States:
  - IDLE: start -> capture num_samples, clear all accumulators and counters, go to RUN.
  - RUN:
    - in_ready=1 while accepted count < target.
    - Sample transfer occurs when in_valid && in_ready.
    - When the accepted count reaches the target, in_ready drops in the same cycle as the last transfer's registered update, and the state goes to DRAIN.
  - DRAIN: wait until both pipeline stages are empty, then go to DONE.
  - DONE: done=1 and results are stable. start -> clear and re-arm exactly as from IDLE, and done falls the cycle after start.
- num_samples=0: IDLE/DONE -> RUN -> DRAIN -> DONE with all results 0 and no samples accepted.
- start is ignored in RUN and DRAIN; the run is not restarted.
- Pipeline, 2 stages:
  - S1 registers exact=a*b (16-bit unsigned) and r_approx.
  - S2 computes diff=r_approx-exact (17-bit signed) and abs=|diff| (16-bit), then updates the accumulators.
  - Results reflect a sample 2 cycles after its transfer.
- Accumulator updates per sample:
  - sum_abs_err += abs.
  - sum_sgn_err += sign-extended diff.
  - max_abs_err = max(max_abs_err, abs).
  - err_count += (abs!=0).
  - sample_count += 1.
- Width rules:
  - No saturation is needed. The maximum abs is 65025, so SUM_W=16+CNT_W is sufficient.
  - All arithmetic is unsigned except diff and sum_sgn_err.
- in_valid without in_ready (IDLE, DRAIN, DONE, or target reached): the sample is dropped with no side effect.
- Asynchronous reset mid-run aborts the run immediately. All state and results return to reset values.
- Results are not frozen during RUN. They update live, but they are valid for the full run only when done=1.

Decomposition:
- Shared package mult_err_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - constants PROD_W=16 and OPER_W=8;
  - the default CNT_W.
- One sub-module, mult_err_datapath, holds the S1/S2 pipeline registers, the exact multiply, diff/abs and the accumulators.
- The top level holds the FSM, the target and accept counter, and the handshake.

Test Plan:
- Reset then idle: hold rst_n=0 and drive in_valid=1 -> all outputs 0 and in_ready=0. Release reset with no start -> nothing accepted.
- Exact model: start with N=4 and samples (3,5,15), (255,255,65025), (0,7,0), (16,16,256) -> done, sample_count=4, and sum_abs_err, sum_sgn_err, max_abs_err and err_count all 0.
- Worst/mixed errors: N=3, samples (255,255,r=0), (10,10,r=110), (8,8,r=60):
  - sum_abs_err=65025+10+4=65039;
  - sum_sgn_err=-65025+10-4=-65019;
  - max_abs_err=65025;
  - err_count=3.
- Handshake: N=2 with in_valid held high for 6 cycles -> exactly 2 transfers, in_ready low afterwards, done 2 cycles after the last transfer, sample_count=2.
- Re-arm and ignore: send start during RUN -> ignored. After done, start with N=1 and sample (2,2,r=5) -> accumulators cleared, sum_abs_err=1, err_count=1, done re-asserts. N=0 -> done with results 0.
- Reset mid-run: N=10, deassert rst_n after 5 transfers -> all outputs 0 and state IDLE. A new start with N=1 runs cleanly.

Source files
------------

// File: rtl/mult_err_pkg.sv
// Shared types and constants for the approximate-multiplier error monitor.
package mult_err_pkg;

  localparam int unsigned OPER_W    = 8;
  localparam int unsigned PROD_W    = 16;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mult_err_datapath.sv
// Two-stage error pipeline: S1 holds the exact product and the approximate
// result, S2 forms the signed/absolute error and updates the accumulators.
module mult_err_datapath
  import mult_err_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned SUM_W = PROD_W + CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 xfer,
  input  logic [OPER_W-1:0]    a,
  input  logic [OPER_W-1:0]    b,
  input  logic [PROD_W-1:0]    r_approx,
  output logic                 s1_vld_next,
  output logic [SUM_W-1:0]     sum_abs_err,
  output logic [SUM_W:0]       sum_sgn_err,
  output logic [PROD_W-1:0]    max_abs_err,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     sample_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                     s1_vld_q, s1_vld_d;
  logic [PROD_W-1:0]        exact_q, exact_d;
  logic [PROD_W-1:0]        r_q, r_d;
  logic [SUM_W-1:0]         sum_abs_q, sum_abs_d;
  logic [SUM_W:0]           sum_sgn_q, sum_sgn_d;
  logic [PROD_W-1:0]        max_abs_q, max_abs_d;
  logic [CNT_W-1:0]         err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]         smp_cnt_q, smp_cnt_d;
  logic signed [PROD_W:0]   diff;
  logic signed [PROD_W:0]   diff_neg;
  logic [PROD_W-1:0]        abs_val;

  always_comb begin
    s1_vld_d = xfer & ~clr;
    exact_d  = exact_q;
    r_d      = r_q;
    if (xfer) begin
      exact_d = {{(PROD_W-OPER_W){1'b0}}, a} * {{(PROD_W-OPER_W){1'b0}}, b};
      r_d     = r_approx;
    end
  end

  // |diff| always fits in PROD_W bits since both operands are PROD_W unsigned.
  always_comb begin
    diff     = $signed({1'b0, r_q}) - $signed({1'b0, exact_q});
    diff_neg = -diff;
    abs_val  = diff[PROD_W] ? diff_neg[PROD_W-1:0] : diff[PROD_W-1:0];
  end

  always_comb begin
    sum_abs_d = sum_abs_q;
    sum_sgn_d = sum_sgn_q;
    max_abs_d = max_abs_q;
    err_cnt_d = err_cnt_q;
    smp_cnt_d = smp_cnt_q;
    if (clr) begin
      sum_abs_d = '0;
      sum_sgn_d = '0;
      max_abs_d = '0;
      err_cnt_d = '0;
      smp_cnt_d = '0;
    end else if (s1_vld_q) begin
      sum_abs_d = sum_abs_q + {{(SUM_W-PROD_W){1'b0}}, abs_val};
      sum_sgn_d = sum_sgn_q + {{(SUM_W-PROD_W){diff[PROD_W]}}, diff};
      if (abs_val > max_abs_q) max_abs_d = abs_val;
      if (abs_val != '0) err_cnt_d = err_cnt_q + CNT_ONE;
      smp_cnt_d = smp_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      exact_q   <= '0;
      r_q       <= '0;
      sum_abs_q <= '0;
      sum_sgn_q <= '0;
      max_abs_q <= '0;
      err_cnt_q <= '0;
      smp_cnt_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      exact_q   <= exact_d;
      r_q       <= r_d;
      sum_abs_q <= sum_abs_d;
      sum_sgn_q <= sum_sgn_d;
      max_abs_q <= max_abs_d;
      err_cnt_q <= err_cnt_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end

  assign s1_vld_next  = s1_vld_d;
  assign sum_abs_err  = sum_abs_q;
  assign sum_sgn_err  = sum_sgn_q;
  assign max_abs_err  = max_abs_q;
  assign err_count    = err_cnt_q;
  assign sample_count = smp_cnt_q;

endmodule

// File: rtl/mult_err_monitor.sv
// Error-metric collector for an 8x8 approximate multiplier: run control,
// sample handshake and the statistics datapath.
module mult_err_monitor
  import mult_err_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned SUM_W = PROD_W + CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPER_W-1:0]    a,
  input  logic [OPER_W-1:0]    b,
  input  logic [PROD_W-1:0]    r_approx,
  output logic                 busy,
  output logic                 done,
  output logic [SUM_W-1:0]     sum_abs_err,
  output logic [SUM_W:0]       sum_sgn_err,
  output logic [PROD_W-1:0]    max_abs_err,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     sample_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             xfer;
  logic             clr;
  logic             s1_vld_next;

  always_comb begin
    in_ready = (state_q == RUN) && (acc_cnt_q < target_q);
    xfer     = in_valid && in_ready;
    clr      = start && ((state_q == IDLE) || (state_q == DONE));
    busy     = (state_q == RUN) || (state_q == DRAIN);
    done     = (state_q == DONE);
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    acc_cnt_d = acc_cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          target_d  = num_samples;
          acc_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (xfer) acc_cnt_d = acc_cnt_q + CNT_ONE;
        if (acc_cnt_d == target_q) state_d = DRAIN;
      end
      // Leave on the edge that retires the last sample so done and final results appear together.
      DRAIN: begin
        if (!s1_vld_next) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      target_q  <= '0;
      acc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  mult_err_datapath #(
    .CNT_W (CNT_W),
    .SUM_W (SUM_W)
  ) u_datapath (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .xfer         (xfer),
    .a            (a),
    .b            (b),
    .r_approx     (r_approx),
    .s1_vld_next  (s1_vld_next),
    .sum_abs_err  (sum_abs_err),
    .sum_sgn_err  (sum_sgn_err),
    .max_abs_err  (max_abs_err),
    .err_count    (err_count),
    .sample_count (sample_count)
  );

endmodule

// File: tb/tb_mult_err_monitor.sv
// Scoreboard bench: each run pushes its hand-computed results; a monitor
// compares them when done rises.
module tb_mult_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] r_approx;
  logic        busy;
  logic        done;
  logic [31:0] sum_abs_err;
  logic [32:0] sum_sgn_err;
  logic [15:0] max_abs_err;
  logic [15:0] err_count;
  logic [15:0] sample_count;

  typedef struct {
    longint cnt;
    longint sabs;
    longint ssgn;
    longint mx;
    longint errs;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic done_prev = 1'b0;

  mult_err_monitor #(
    .CNT_W (16),
    .SUM_W (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_samples  (num_samples),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .r_approx     (r_approx),
    .busy         (busy),
    .done         (done),
    .sum_abs_err  (sum_abs_err),
    .sum_sgn_err  (sum_sgn_err),
    .max_abs_err  (max_abs_err),
    .err_count    (err_count),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_results(input string tag, input exp_t e);
    check({tag, ".sample_count"}, longint'(sample_count), e.cnt);
    check({tag, ".sum_abs_err"}, longint'(sum_abs_err), e.sabs);
    check({tag, ".sum_sgn_err"}, longint'($signed(sum_sgn_err)), e.ssgn);
    check({tag, ".max_abs_err"}, longint'(max_abs_err), e.mx);
    check({tag, ".err_count"}, longint'(err_count), e.errs);
  endtask

  // Monitor: compare against the oldest expected run whenever done rises.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        check_results("run", sb_q.pop_front());
      end
    end
    done_prev = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(input longint c, input longint s, input longint g,
                              input longint m, input longint e);
    exp_t x;
    x.cnt = c; x.sabs = s; x.ssgn = g; x.mx = m; x.errs = e;
    return x;
  endfunction

  // All drivers below are entered and left at posedge+1.
  task automatic pulse_start(input logic [15:0] n);
    start = 1'b1;
    num_samples = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] rv);
    int t = 0;
    a = av; b = bv; r_approx = rv;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!done) check("done_timeout", 0, 1);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"}, longint'(in_ready), 0);
    check({tag, ".busy"}, longint'(busy), 0);
    check({tag, ".done"}, longint'(done), 0);
    check_results(tag, mk(0, 0, 0, 0, 0));
  endtask

  initial begin
    int xfers;
    int last_x;
    int first_d;

    rst_n = 1'b0;
    start = 1'b0;
    num_samples = 16'd0;
    in_valid = 1'b1;
    a = 8'd9; b = 8'd9; r_approx = 16'd1;

    // Reset held with in_valid asserted, then idle with no start.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle.in_ready", longint'(in_ready), 0);
    check("idle.sample_count", longint'(sample_count), 0);
    check("idle.busy", longint'(busy), 0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Exact products: no error.
    sb_q.push_back(mk(4, 0, 0, 0, 0));
    pulse_start(16'd4);
    check("run.busy", longint'(busy), 1);
    send(8'd3, 8'd5, 16'd15);
    send(8'd255, 8'd255, 16'd65025);
    send(8'd0, 8'd7, 16'd0);
    send(8'd16, 8'd16, 16'd256);
    wait_done();

    // Worst case plus mixed-sign errors.
    sb_q.push_back(mk(3, 65039, -65019, 65025, 3));
    pulse_start(16'd3);
    send(8'd255, 8'd255, 16'd0);
    send(8'd10, 8'd10, 16'd110);
    send(8'd8, 8'd8, 16'd60);
    wait_done();

    // Handshake: in_valid held 6 cycles, only 2 transfers accepted.
    sb_q.push_back(mk(2, 2, 2, 1, 2));
    pulse_start(16'd2);
    a = 8'd3; b = 8'd3; r_approx = 16'd10;
    in_valid = 1'b1;
    xfers = 0; last_x = -1; first_d = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        xfers++;
        last_x = i;
      end
      if (done && first_d < 0) first_d = i;
      if (i == 5) in_valid = 1'b0;
    end
    check("hs.transfers", xfers, 2);
    check("hs.done_latency", first_d - last_x, 2);
    check("hs.in_ready_after", longint'(in_ready), 0);
    @(posedge clk); #1;

    // Start during RUN is ignored; target stays 3.
    sb_q.push_back(mk(3, 4, 4, 4, 1));
    pulse_start(16'd3);
    send(8'd2, 8'd3, 16'd6);
    pulse_start(16'd1);
    check("ignore.busy", longint'(busy), 1);
    check("ignore.sample_count", longint'(sample_count), 1);
    send(8'd4, 8'd4, 16'd20);
    send(8'd5, 8'd5, 16'd25);
    wait_done();

    // Re-arm from DONE: accumulators cleared, done drops next cycle.
    sb_q.push_back(mk(1, 1, 1, 1, 1));
    pulse_start(16'd1);
    @(negedge clk);
    check("rearm.done_low", longint'(done), 0);
    check("rearm.cleared", longint'(sum_abs_err), 0);
    @(posedge clk); #1;
    send(8'd2, 8'd2, 16'd5);
    wait_done();

    // Zero-length run.
    sb_q.push_back(mk(0, 0, 0, 0, 0));
    pulse_start(16'd0);
    check("n0.in_ready", longint'(in_ready), 0);
    wait_done();

    // Reset mid-run aborts everything.
    pulse_start(16'd10);
    for (int i = 0; i < 5; i++) send(8'd1, 8'd1, 16'd3);
    @(posedge clk); #1;
    check("midrun.sample_count", longint'(sample_count), 5);
    check("midrun.sum_abs_err", longint'(sum_abs_err), 10);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    sb_q.push_back(mk(1, 3, -3, 3, 1));
    pulse_start(16'd1);
    send(8'd7, 8'd9, 16'd60);
    wait_done();

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
